// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative 32-bit divider among NREQ requesters.
// Signed jobs are run on operand magnitudes and sign-corrected after the 32 iterations.

// Iterative restoring divider: loads on start, performs one quotient bit per step cycle.
module division (
  input  logic        clock,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] acc;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [32:0] shifted;
  logic [32:0] trial;

  // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
  always_comb begin
    shifted = {acc, quo[31]};
    trial   = shifted - {1'b0, dvs};
  end

  // Divider state has no reset: every job begins with a start that reloads it.
  always_ff @(posedge clock) begin
    if (start) begin
      acc <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      if (!trial[32]) begin
        acc <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        acc <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = acc;

endmodule

module div_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_signed,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_q,
  output logic [31:0]          resp_r,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   id;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_s;
  logic            sa;
  logic            sb;
  logic [31:0]     ma;
  logic [31:0]     mb;
  logic [5:0]      cnt;
  logic            div_start;
  logic            div_step;
  logic [31:0]     dq;
  logic [31:0]     dr;

  division u_div (
    .clock     (clock),
    .start     (div_start),
    .step      (div_step),
    .dividend  (ma),
    .divisor   (mb),
    .quotient  (dq),
    .remainder (dr)
  );

  // Pick the first valid requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gidx  = IW'((int'(ptr) + k) % NREQ);
      end
    end
    grant = found ? (NREQ'(1) << gidx) : '0;
    sel_a = req_a[32*int'(gidx) +: 32];
    sel_b = req_b[32*int'(gidx) +: 32];
    sel_s = req_signed[gidx];
  end

  // Sequencer next state plus the divider start/step strobes.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    div_step   = 1'b0;
    case (state)
      IDLE: if (found) state_next = (sel_b == 32'd0) ? RESP : LOAD;
      LOAD: begin
        div_start  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        div_step = 1'b1;
        if (cnt == 6'd31) state_next = FIX;
      end
      FIX:  state_next = RESP;
      RESP: if (resp_ready[id]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Job capture at accept, iteration counting, and sign-corrected result registration.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr    <= '0;
      id     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      cnt    <= '0;
      resp_q <= '0;
      resp_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id  <= gidx;
            ptr <= IW'((int'(gidx) + 1) % NREQ);
            sa  <= sel_s & sel_a[31];
            sb  <= sel_s & sel_b[31];
            ma  <= (sel_s & sel_a[31]) ? -sel_a : sel_a;
            mb  <= (sel_s & sel_b[31]) ? -sel_b : sel_b;
            if (sel_b == 32'd0) begin
              resp_q <= 32'hFFFF_FFFF;
              resp_r <= sel_a;
            end
          end
        end
        LOAD: cnt <= '0;
        RUN:  cnt <= cnt + 6'd1;
        FIX: begin
          resp_q <= (sa ^ sb) ? -dq : dq;
          resp_r <= sa ? -dr : dr;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are decoded from the current state and captured requester id.
  always_comb begin
    req_ready  = (state == IDLE) ? grant : '0;
    resp_valid = (state == RESP) ? (NREQ'(1) << id) : '0;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: scoreboard of expected responses with latency tracking.
module tb_div_arbiter;

  localparam int NREQ = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_signed;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [31:0]         resp_q;
  logic [31:0]         resp_r;
  logic                busy;

  div_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_q     (resp_q),
    .resp_r     (resp_r),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   grantLog[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   startPulses = 0;
  bit   seen = 1'b0;

  int              monIdx;
  logic [31:0]     monQ;
  logic [31:0]     monR;
  logic [NREQ-1:0] monWant;
  exp_t            monE;

  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint la;
    longint lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      la = $signed(a);
      lb = $signed(b);
      q = 32'(la / lb);
      r = 32'(la % lb);
    end
  endfunction

  // Posedge counter used to timestamp accepts and responses.
  always @(posedge clock) cycle <= cycle + 1;

  // Negedge monitor: pushes expectations on accept, checks latency and data on response.
  always @(negedge clock) begin
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (dut.div_start) startPulses++;
      checks++;
      if (busy && (req_ready != '0)) begin
        errors++;
        $display("[TB] FAIL ready_while_busy: req_ready=%b required 0", req_ready);
      end
      if ((req_valid & req_ready) != '0) begin
        monIdx = 0;
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) monIdx = i;
        checks++;
        if (sbq.size() != 0) begin
          errors++;
          $display("[TB] FAIL overlap: accept with %0d jobs outstanding, required 0", sbq.size());
        end
        model(req_signed[monIdx], req_a[32*monIdx +: 32], req_b[32*monIdx +: 32], monQ, monR);
        monE.id  = monIdx;
        monE.q   = monQ;
        monE.r   = monR;
        monE.due = cycle + 1 + ((req_b[32*monIdx +: 32] == 32'd0) ? 0 : 34);
        sbq.push_back(monE);
        grantLog.push_back(monIdx);
      end
      if ((resp_valid != '0) && !seen) begin
        seen = 1'b1;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_resp: resp_valid=%b with empty scoreboard", resp_valid);
        end else if (cycle != sbq[0].due) begin
          errors++;
          $display("[TB] FAIL latency: resp_valid at cycle %0d, required %0d", cycle, sbq[0].due);
        end
      end
      if ((resp_valid & resp_ready) != '0) begin
        seen = 1'b0;
        if (sbq.size() != 0) begin
          monE = sbq.pop_front();
          monWant = '0;
          monWant[monE.id] = 1'b1;
          checks++;
          if (resp_valid !== monWant || resp_q !== monE.q || resp_r !== monE.r) begin
            errors++;
            $display("[TB] FAIL resp_data: valid=%b q=%h r=%h, required valid=%b q=%h r=%h",
                     resp_valid, resp_q, resp_r, monWant, monE.q, monE.r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int i, input bit s, input logic [31:0] a, input logic [31:0] b);
    int n;
    req_signed[i] = s;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
    n = 0;
    #1;
    while (!(req_valid[i] && req_ready[i]) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL accept_timeout: req %0d not granted, req_ready=%b", i, req_ready);
    end
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL done_timeout: busy=%b pending=%0d, required idle", busy, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_signed = '0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    checks++;
    if (resp_valid !== '0 || resp_q !== 32'd0 || resp_r !== 32'd0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b q=%h r=%h busy=%b ready=%b, required all 0",
               resp_valid, resp_q, resp_r, busy, req_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int p0;
    int bad;
    resp_ready = 2'b01;
    p0 = startPulses;
    issue(0, 1'b0, 32'd100, 32'd7);
    bad = 0;
    for (int k = 0; k < 35; k++) begin
      if (busy !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_window: %0d low cycles, busy after=%b, required 0 and 0", bad, busy);
    end
    checks++;
    if (startPulses != p0 + 1) begin
      errors++;
      $display("[TB] FAIL start_count: %0d pulses, required 1", startPulses - p0);
    end
    wait_done(60);
  endtask

  task automatic test_signed();
    resp_ready = 2'b11;
    issue(1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(60);
    issue(0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(60);
    issue(1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(60);
    issue(0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(60);
  endtask

  task automatic test_div_zero();
    int p0;
    resp_ready = 2'b11;
    p0 = startPulses;
    issue(0, 1'b0, 32'd5, 32'd0);
    wait_done(20);
    issue(1, 1'b1, 32'd5, 32'd0);
    wait_done(20);
    issue(0, 1'b1, 32'hFFFF_FFF0, 32'd0);
    wait_done(20);
    checks++;
    if (startPulses != p0) begin
      errors++;
      $display("[TB] FAIL zero_start: %0d start pulses, required 0", startPulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int want[4] = '{0, 1, 0, 1};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grantLog.delete();
    resp_ready = 2'b11;
    req_signed = 2'b10;
    req_a = {32'hFFFF_FFF7, 32'd50};
    req_b = {32'd4, 32'd5};
    req_valid = 2'b11;
    n = 0;
    while (grantLog.size() < 4 && n < 300) begin
      tick();
      n++;
    end
    req_valid = '0;
    checks++;
    if (grantLog.size() < 4) begin
      errors++;
      $display("[TB] FAIL rr_timeout: %0d grants seen, required 4", grantLog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grantLog[k] != want[k]) begin
          errors++;
          $display("[TB] FAIL rr_order[%0d]: grant %0d, required %0d", k, grantLog[k], want[k]);
        end
      end
    end
    wait_done(60);
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] hq;
    logic [31:0] hr;
    int bad;
    resp_ready = 2'b10;
    req_signed[1] = 1'b0;
    req_a[63:32] = 32'd77;
    req_b[63:32] = 32'd7;
    req_valid[1] = 1'b1;
    issue(0, 1'b0, 32'd1000, 32'd33);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    hq = resp_q;
    hr = resp_r;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (resp_valid !== 2'b01 || resp_q !== hq || resp_r !== hr || req_ready !== 2'b00) bad++;
    end
    checks++;
    if (n >= 60 || bad != 0 || hq !== 32'd30 || hr !== 32'd10) begin
      errors++;
      $display("[TB] FAIL hold: wait=%0d unstable=%0d q=%h r=%h, required q=1e r=a stable", n, bad, hq, hr);
    end
    resp_ready = 2'b11;
    n = 0;
    #1;
    while (!(req_valid[1] && req_ready[1]) && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid[1] = 1'b0;
    checks++;
    if (n >= 20) begin
      errors++;
      $display("[TB] FAIL post_hold_grant: req 1 not granted after release");
    end
    wait_done(60);
  endtask

  task automatic test_reset_mid();
    resp_ready = 2'b11;
    issue(0, 1'b0, 32'd1000, 32'd3);
    for (int k = 0; k < 16; k++) tick();
    checks++;
    if (dut.cnt !== 6'd15) begin
      errors++;
      $display("[TB] FAIL mid_count: cnt=%0d, required 15", dut.cnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (resp_valid !== '0 || resp_q !== 32'd0 || resp_r !== 32'd0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b q=%h r=%h busy=%b ready=%b, required all 0",
               resp_valid, resp_q, resp_r, busy, req_ready);
    end
    reset = 1'b0;
    sbq.delete();
    tick();
    issue(1, 1'b0, 32'd9, 32'd3);
    wait_done(60);
    issue(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(60);
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
